thread_dispatch: RTL and testbench

THREAD_DISPATCH -- requirements
Module: thread_dispatch

---
 rtl/thread_dispatch.sv | 129 ++++++++++++
 tb/tb_thread_dispatch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/thread_dispatch.sv
// Four-thread context-switch dispatcher: priority-selects a runnable thread,
// saves/restores per-thread PCs and presents the running thread's PC to fetch.
module thread_dispatch (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        sched_0q,
    input  logic        sched_1q,
    input  logic        sched_2q,
    input  logic        sched_3q,
    input  logic        LOCKED,
    input  logic        RPT_not_z,
    input  logic [19:0] pc_next,
    output logic [1:0]  thread_id,
    output logic [19:0] pc_fetch,
    output logic        run,
    output logic        switch_stb,
    output logic [7:0]  switch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_tid;
    logic [1:0]  r_target;
    logic        r_prev_run;
    logic [19:0] r_pc_fetch;
    logic        r_run;
    logic        r_stb;
    logic [7:0]  r_cnt;
    logic [19:0] r_spc [4];

    logic [3:0]  w_req;
    logic        w_none;
    logic [1:0]  w_want;
    logic        w_frz;
    logic        w_load_tgt;
    logic        w_save;

    assign w_req  = {sched_3q, sched_2q, sched_1q, sched_0q};
    assign w_none = ~|w_req;
    assign w_frz  = LOCKED | RPT_not_z;

    always_comb begin
        w_want = 2'd0;
        if (w_req[0])      w_want = 2'd0;
        else if (w_req[1]) w_want = 2'd1;
        else if (w_req[2]) w_want = 2'd2;
        else if (w_req[3]) w_want = 2'd3;
    end

    always_comb begin
        w_next     = ST_IDLE;
        w_load_tgt = 1'b0;
        w_save     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_none) begin
                    w_next     = ST_SWITCH;
                    w_load_tgt = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_none) begin
                    w_next = ST_IDLE;
                    w_save = 1'b1;
                end else if (w_want != r_tid) begin
                    w_next     = ST_SWITCH;
                    w_load_tgt = 1'b1;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_SWITCH: begin
                w_next = ST_RUN;
                w_save = r_prev_run;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Nonblocking spc write and read in the same edge gives read-before-write.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= ST_IDLE;
            r_tid      <= 2'd0;
            r_target   <= 2'd0;
            r_prev_run <= 1'b0;
            r_pc_fetch <= 20'h00000;
            r_run      <= 1'b0;
            r_stb      <= 1'b0;
            r_cnt      <= 8'h00;
            r_spc[0]   <= 20'h00100;
            r_spc[1]   <= 20'h00140;
            r_spc[2]   <= 20'h00180;
            r_spc[3]   <= 20'h001C0;
        end else if (w_frz) begin
            r_stb <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stb   <= (w_next == ST_SWITCH);
            r_run   <= (w_next == ST_RUN);
            if (w_load_tgt) begin
                r_target   <= w_want;
                r_prev_run <= (r_state == ST_RUN);
            end
            if (w_save)
                r_spc[r_tid] <= pc_next;
            if (r_state == ST_RUN)
                r_pc_fetch <= pc_next;
            if (r_state == ST_SWITCH) begin
                r_tid      <= r_target;
                r_pc_fetch <= r_spc[r_target];
                r_cnt      <= r_cnt + 8'd1;
            end
        end
    end

    assign thread_id  = r_tid;
    assign pc_fetch   = r_pc_fetch;
    assign run        = r_run;
    assign switch_stb = r_stb;
    assign switch_cnt = r_cnt;

endmodule

// File: tb/tb_thread_dispatch.sv
// Directed bench for thread_dispatch: reset, dispatch, PC save/restore,
// priority, freeze, counter wrap and asynchronous reset.
module tb_thread_dispatch;

    logic        CLK;
    logic        RESETn;
    logic        sched_0q, sched_1q, sched_2q, sched_3q;
    logic        LOCKED, RPT_not_z;
    logic [19:0] pc_next;
    logic [1:0]  thread_id;
    logic [19:0] pc_fetch;
    logic        run, switch_stb;
    logic [7:0]  switch_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    thread_dispatch dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .sched_0q   (sched_0q),
        .sched_1q   (sched_1q),
        .sched_2q   (sched_2q),
        .sched_3q   (sched_3q),
        .LOCKED     (LOCKED),
        .RPT_not_z  (RPT_not_z),
        .pc_next    (pc_next),
        .thread_id  (thread_id),
        .pc_fetch   (pc_fetch),
        .run        (run),
        .switch_stb (switch_stb),
        .switch_cnt (switch_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] tid, input logic [19:0] pc,
                             input logic rn, input logic stb, input logic [7:0] cnt);
        check_eq({tag, ".thread_id"},  32'(thread_id),  32'(tid));
        check_eq({tag, ".pc_fetch"},   32'(pc_fetch),   32'(pc));
        check_eq({tag, ".run"},        32'(run),        32'(rn));
        check_eq({tag, ".switch_stb"}, 32'(switch_stb), 32'(stb));
        check_eq({tag, ".switch_cnt"}, 32'(switch_cnt), 32'(cnt));
    endtask

    initial begin
        RESETn = 1'b0;
        {sched_0q, sched_1q, sched_2q, sched_3q} = 4'b0000;
        LOCKED = 1'b0; RPT_not_z = 1'b0;
        pc_next = 20'h00000;
        tick(); tick();
        check_all("reset", 2'd0, 20'h00000, 1'b0, 1'b0, 8'h00);
        RESETn = 1'b1;
        tick();
        check_all("idle", 2'd0, 20'h00000, 1'b0, 1'b0, 8'h00);

        // Dispatch thread 2 from idle
        sched_2q = 1'b1;
        tick();
        check_all("sw2", 2'd0, 20'h00000, 1'b0, 1'b1, 8'h00);
        tick();
        check_all("run2", 2'd2, 20'h00180, 1'b1, 1'b0, 8'h01);

        // Preempt by thread 0, then resume thread 2 at saved PC
        pc_next = 20'h00ABC;
        tick();
        check_eq("run2.pc_follow", 32'(pc_fetch), 32'h00ABC);
        sched_0q = 1'b1;
        tick();
        check_all("sw0", 2'd2, 20'h00ABC, 1'b0, 1'b1, 8'h01);
        tick();
        check_all("run0", 2'd0, 20'h00100, 1'b1, 1'b0, 8'h02);
        pc_next = 20'h00200;
        sched_0q = 1'b0;
        tick();
        check_eq("sw2b.stb", 32'(switch_stb), 32'd1);
        tick();
        check_all("resume2", 2'd2, 20'h00ABC, 1'b1, 1'b0, 8'h03);

        // Go idle, then 0 and 3 together
        sched_2q = 1'b0;
        tick();
        check_all("idle2", 2'd2, 20'h00200, 1'b0, 1'b0, 8'h03);
        sched_0q = 1'b1; sched_3q = 1'b1;
        tick();
        check_eq("sw03.stb", 32'(switch_stb), 32'd1);
        tick();
        check_all("run03", 2'd0, 20'h00200, 1'b1, 1'b0, 8'h04);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("prio0.tid", 32'(thread_id), 32'd0);
            check_eq("prio0.stb", 32'(switch_stb), 32'd0);
        end

        // Freeze during switch to thread 3
        sched_0q = 1'b0;
        tick();
        check_all("sw3", 2'd0, 20'h00200, 1'b0, 1'b1, 8'h04);
        LOCKED = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("lock", 2'd0, 20'h00200, 1'b0, 1'b0, 8'h04);
        end
        LOCKED = 1'b0;
        tick();
        check_all("unlock", 2'd3, 20'h001C0, 1'b1, 1'b0, 8'h05);

        // Repeat-active freeze in RUN
        pc_next = 20'h00333;
        RPT_not_z = 1'b1;
        tick();
        check_eq("rpt.pc_hold", 32'(pc_fetch), 32'h001C0);
        RPT_not_z = 1'b0;
        tick();
        check_eq("rpt.pc_go", 32'(pc_fetch), 32'h00333);

        // 251 more switches: 5 -> 256 wraps to 0
        for (int i = 0; i < 251; i++) begin
            sched_0q = (i % 2 == 0);
            tick(); tick();
            if (i == 249) check_eq("cnt.ff", 32'(switch_cnt), 32'hFF);
        end
        check_eq("cnt.wrap", 32'(switch_cnt), 32'h00);
        check_eq("wrap.tid", 32'(thread_id), 32'd0);

        sched_0q = 1'b0;
        tick(); tick();
        check_all("pre_rst", 2'd3, 20'h00333, 1'b1, 1'b0, 8'h01);
        tick();
        #2 RESETn = 1'b0;
        #1;
        check_all("async_rst", 2'd0, 20'h00000, 1'b0, 1'b0, 8'h00);
        @(negedge CLK);
        RESETn = 1'b1;
        tick();
        check_eq("post_rst.stb", 32'(switch_stb), 32'd1);
        tick();
        check_all("post_rst", 2'd3, 20'h001C0, 1'b1, 1'b0, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
